// File: rtl/instr_fetch_decode_if.sv
// Signal bundle for the instruction fetch/decode block.
// The load port, run control and decoded outputs travel together.
interface instr_fetch_decode_if;
  logic        Ld_en;
  logic [7:0]  Ld_addr;
  logic [23:0] Ld_data;
  logic        Start;
  logic        Stall;
  logic [3:0]  func;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [7:0]  addr;
  logic        Valid;
  logic [7:0]  PC;
  logic        Halted;

  modport master (
    output Ld_en, Ld_addr, Ld_data, Start, Stall,
    input  func, rd, rs1, rs2, addr, Valid, PC, Halted
  );

  modport slave (
    input  Ld_en, Ld_addr, Ld_data, Start, Stall,
    output func, rd, rs1, rs2, addr, Valid, PC, Halted
  );
endinterface

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode: 256x24 program memory, PC sequencer and registered
// field decode.
//
// state | meaning
// IDLE  | after reset; memory loadable, waiting for Start
// RUN   | fetching and issuing one word per unstalled edge
// HALT  | stopped on a func==F word; memory loadable, Start restarts at PC 0
module instr_fetch_decode (
  input logic Clock,
  input logic Reset_n,
  instr_fetch_decode_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t      state;
  logic [23:0] mem [256];
  logic [23:0] word;
  logic [7:0]  pc;
  logic [3:0]  func_q, rd_q, rs1_q, rs2_q;
  logic [7:0]  addr_q;
  logic        valid_q;
  logic        halted_q;

  assign word = mem[pc];

  // Loads are refused while running so a program cannot modify itself mid-run.
  always_ff @(posedge Clock) begin
    if (bus.Ld_en && (state != RUN)) begin
      mem[bus.Ld_addr] <= bus.Ld_data;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      pc       <= 8'd0;
      func_q   <= 4'd0;
      rd_q     <= 4'd0;
      rs1_q    <= 4'd0;
      rs2_q    <= 4'd0;
      addr_q   <= 8'd0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (bus.Start && !bus.Ld_en) begin
            state    <= RUN;
            pc       <= 8'd0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
          end
        end
        RUN: begin
          if (!bus.Stall) begin
            if (word[23:20] == 4'hF) begin
              // Halt word is never issued; PC stays pointing at it.
              state    <= HALT;
              valid_q  <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              func_q  <= word[23:20];
              rd_q    <= word[19:16];
              rs1_q   <= word[15:12];
              rs2_q   <= word[11:8];
              addr_q  <= word[7:0];
              valid_q <= 1'b1;
              pc      <= pc + 8'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.func   = func_q;
  assign bus.rd     = rd_q;
  assign bus.rs1    = rs1_q;
  assign bus.rs2    = rs2_q;
  assign bus.addr   = addr_q;
  assign bus.Valid  = valid_q;
  assign bus.PC     = pc;
  assign bus.Halted = halted_q;

endmodule

// File: doc/instr_fetch_decode.md
INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

Interface
REQ-001 SHALL provide Clock, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL provide Reset_n, input, 1: asynchronous reset, active low.
REQ-003 SHALL provide Ld_en, input, 1: instruction-memory write enable.
REQ-004 SHALL provide Ld_addr, input, 8: instruction-memory write address.
REQ-005 SHALL provide Ld_data, input, 24: instruction word {func[23:20], rd[19:16], rs1[15:12], rs2[11:8], addr[7:0]}.
REQ-006 SHALL provide Start, input, 1: begin execution at PC 0.
REQ-007 SHALL provide Stall, input, 1: downstream back-pressure; hold all outputs and PC.
REQ-008 SHALL provide func, output, 4: decoded ALU function code, registered.
REQ-009 SHALL provide rd, rs1, rs2, output, 4 each: decoded register indices, registered.
REQ-010 SHALL provide addr, output, 8: decoded memory address, registered.
REQ-011 SHALL provide Valid, output, 1: decoded fields hold an issued instruction this cycle.
REQ-012 SHALL provide PC, output, 8: current fetch address.
REQ-013 SHALL provide Halted, output, 1: high in HALT state.

Function
REQ-014 SHALL contain a 256 x 24 instruction memory, written only by the load port, read asynchronously at PC.
REQ-015 SHALL implement FSM states IDLE, RUN, HALT.
REQ-016 Ld_en high in IDLE or HALT SHALL write Ld_data to mem[Ld_addr] at the clock edge; Ld_en in RUN SHALL be ignored.
REQ-017 Start high with Ld_en low in IDLE or HALT SHALL set PC to 0 and enter RUN; Valid stays 0 that cycle.
REQ-018 Start and Ld_en high together SHALL perform the write only; Start ignored.
REQ-019 Start in RUN SHALL be ignored.
REQ-020 In RUN with Stall low and mem[PC].func != 4'hF, each edge SHALL register the decoded fields of mem[PC] onto outputs, set Valid to 1, and increment PC.
REQ-021 Latency SHALL be one cycle: the instruction at PC appears on outputs the edge after PC presents it; first issued instruction (mem[0]) appears one edge after the Start edge.
REQ-022 PC SHALL wrap 255 -> 0 modulo 256 without halting.
REQ-023 In RUN with Stall high, PC, all decoded outputs and Valid SHALL hold their values; no fetch advance.
REQ-024 In RUN with Stall low and mem[PC].func == 4'hF, SHALL not issue that word: Valid to 0, decoded outputs hold, PC holds at the halt address, state to HALT.
REQ-025 Stall high while mem[PC] is a halt word SHALL defer the halt until Stall is low.
REQ-026 In IDLE and HALT, Valid SHALL be 0 and decoded outputs SHALL hold.
REQ-027 Halted SHALL be 1 exactly while in HALT; 0 in IDLE and RUN.
REQ-028 func codes 0-11 SHALL pass through unmodified; codes 12-14 SHALL issue as normal instructions (no local checking).

Reset
REQ-029 Reset_n low SHALL immediately force state IDLE, PC 0, Valid 0, Halted 0, and func, rd, rs1, rs2, addr to 0, regardless of clock.
REQ-030 Reset assertion mid-RUN SHALL abort execution with no further issue; instruction-memory contents SHALL NOT be cleared.
REQ-031 After Reset_n deasserts, the block SHALL remain in IDLE until Start.

Verification
REQ-032 Load mem[0]=24'h0123_45, mem[1]=24'h1456_78, mem[2]=24'hF00000; Start -> outputs (func,rd,rs1,rs2,addr)=(0,1,2,3,0x45) Valid=1, then (1,4,5,6,0x78) Valid=1, then Valid=0, Halted=1, PC=2.
REQ-033 Same program, Stall high for 3 cycles after first issue -> first instruction held 4 cycles with Valid=1, PC=1 throughout; second issues the edge after Stall drops.
REQ-034 No halt word loaded (func=0 in all 256 words); run 257 issues -> PC wraps 255 -> 0, issue 257 shows mem[0] fields, Halted stays 0.
REQ-035 Reset_n pulsed low while PC=5 in RUN -> outputs all 0, IDLE; Start again -> mem[0] fields reissued unchanged.
REQ-036 Ld_en with Ld_addr=1, Ld_data=24'hFFFFFF during RUN -> mem[1] unchanged, original mem[1] issued; Start+Ld_en together in HALT -> write occurs, state remains HALT.
